draw_player_ctl: RTL and testbench
==================================

DRAW_PLAYER_CTL -- requirements
Module: draw_player_ctl

Interface
REQ-001 Parameter: KEY_COLOR, default 12'h0F0, transparent sprite colour; ROM pixels equal to it are not drawn.
REQ-002 Parameter: SPRITE_W, default 64, sprite width/height in pixels; fixed to 64 by the 12-bit ROM address format.
REQ-003 clk  input  1  pixel clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 hcount_in, vcount_in  input  11 each  current pixel coordinates from the upstream timing chain.
REQ-006 hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each  upstream sync and blanking flags.
REQ-007 rgb_in  input  12  background pixel colour.
REQ-008 xpos, ypos  input  12 each  sprite top-left corner, unsigned screen coordinates.
REQ-009 mirror  input  1  1 = draw the sprite horizontally flipped (player facing left).
REQ-010 visible  input  1  1 = sprite enabled.
REQ-011 rom_addr  output  12  sprite ROM address {addry[5:0], addrx[5:0]}, registered.
REQ-012 rom_rgb  input  12  ROM data; valid one clk after rom_addr.
REQ-013 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  output  same widths as the inputs  delayed and composed stream.

Function
REQ-014 xpos, ypos, mirror and visible SHALL be captured into shadow registers only on the cycle where vsync_in is 1 and its registered previous value is 0.
REQ-015 Inputs SHALL NOT affect drawing mid-frame; a position change during active video takes effect on the next frame.
REQ-016 Stage 1 (cycle N+1) SHALL register all timing signals and rgb_in.
REQ-017 Stage 1 SHALL compute the in-box flag and rom_addr from the cycle-N hcount_in and vcount_in.
REQ-018 in_box = (hcount >= xs) && (hcount < xs+64) && (vcount >= ys) && (vcount < ys+64).
REQ-019 The in-box comparison SHALL use 13-bit zero-extended arithmetic so that xs+64 never wraps.
REQ-020 dx = (hcount - xs)[5:0] and dy = (vcount - ys)[5:0].
REQ-021 addrx SHALL be dx when mirror=0 and 63-dx when mirror=1; addry SHALL be dy.
REQ-022 When in_box=0, rom_addr SHALL hold 12'h000.
REQ-023 Stage 2 (cycle N+2) SHALL output all timing signals delayed by exactly 2 clk relative to the inputs.
REQ-024 rgb_out SHALL be 12'h000 when the stage-2 hblnk or vblnk is 1.
REQ-025 Otherwise, rgb_out SHALL be rom_rgb when stage-2 in_box=1, shadow visible=1 and rom_rgb != KEY_COLOR.
REQ-026 In all remaining cases, rgb_out SHALL be the stage-2 rgb_in.
REQ-027 Total latency SHALL be 2 clk for every output; throughput SHALL be one pixel per clk with no stalls.
REQ-028 A sprite partly off-screen (xs > 1024-64 or ys > 768-64) SHALL be clipped naturally by the counters, with no wrap to the left or top edge.

Reset
REQ-029 On rst=1 at a clk edge, all pipeline registers and outputs SHALL become 0, including rom_addr=12'h000 and rgb_out=12'h000.
REQ-030 On reset, shadow xs=ys=0, mirror=0 and visible=0, so no sprite is drawn until the first vsync rising edge after reset.
REQ-031 Reset asserted mid-frame SHALL zero the pipeline within one clk; after rst deasserts, the first valid outputs appear 2 clk later.

Verification
REQ-032 Scenario: xpos=100, ypos=200, visible=1, mirror=0, after a vsync edge; hcount=100, vcount=200 -> rom_addr=12'h000 one clk later, rgb_out=rom_rgb two clk later.
REQ-033 Scenario: same position with mirror=1; hcount=100, vcount=203 -> rom_addr={6'd3, 6'd63}.
REQ-034 Scenario: ROM returns KEY_COLOR inside the box with rgb_in=12'h123 -> rgb_out=12'h123; hcount=164 -> in_box=0 and rgb_out=rgb_in.
REQ-035 Scenario: xpos changed from 100 to 300 mid-frame -> the sprite stays at 100 until the next vsync rising edge, then moves to 300.
REQ-036 Scenario: xpos=1000 -> pixels drawn for hcount 1000..1023 only; hcount 0..39 is not drawn.
REQ-037 Scenario: rst pulse mid-line -> all outputs 0 the next clk; the sprite is hidden until the next vsync edge; hblnk_out tracks hblnk_in with exactly 2-clk delay throughout.

Source files
------------

// File: rtl/draw_player_ctl.sv
// draw_player_ctl
// Overlays a 64x64 player sprite, read from an external synchronous ROM,
// onto a pixel stream from the upstream timing chain. Every output lags
// its input by exactly two clocks. The design accepts one pixel per clock
// and never stalls.
//
// The sprite position, mirror and visible controls are sampled into shadow
// registers on the rising edge of vsync_in. A frame is therefore never torn
// by a position change made during active video.
//
// Ports
//   clk, rst                     pixel clock, synchronous active-high reset
//   hcount_in, vcount_in [10:0]  current pixel coordinates
//   hsync_in, vsync_in           upstream sync flags
//   hblnk_in, vblnk_in           upstream blanking flags
//   rgb_in [11:0]                background colour
//   xpos, ypos [11:0]            sprite top-left corner
//   mirror                       1 = horizontally flipped sprite
//   visible                      1 = sprite enabled
//   rom_addr [11:0]              registered ROM address {row, column}
//   rom_rgb [11:0]               ROM data, valid one clock after rom_addr
//   *_out                        the same stream delayed by two clocks,
//                                with the sprite composed into rgb_out
module draw_player_ctl #(
  parameter logic [11:0] KEY_COLOR = 12'h0F0,
  parameter int          SPRITE_W  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mirror,
  input  logic        visible,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  logic        r_vsyncPrev;
  logic [11:0] r_xs;
  logic [11:0] r_ys;
  logic        r_mirror;
  logic        r_visible;

  logic [10:0] r_s1Hcount;
  logic [10:0] r_s1Vcount;
  logic        r_s1Hsync;
  logic        r_s1Vsync;
  logic        r_s1Hblnk;
  logic        r_s1Vblnk;
  logic [11:0] r_s1Rgb;
  logic        r_s1InBox;
  logic        r_s1Visible;
  logic [11:0] r_romAddr;

  logic [10:0] r_s2Hcount;
  logic [10:0] r_s2Vcount;
  logic        r_s2Hsync;
  logic        r_s2Vsync;
  logic        r_s2Hblnk;
  logic        r_s2Vblnk;
  logic [11:0] r_s2Rgb;
  logic        r_s2InBox;
  logic        r_s2Visible;

  logic [12:0] w_h13;
  logic [12:0] w_v13;
  logic [12:0] w_xs13;
  logic [12:0] w_ys13;
  logic        w_inBox;
  logic [5:0]  w_dx;
  logic [5:0]  w_dy;
  logic [5:0]  w_addrx;
  logic [11:0] w_romAddr;

  // The shadow controls only change on a vsync rising edge. After reset they
  // are cleared, so the sprite stays hidden until the first such edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsyncPrev <= 1'b0;
      r_xs        <= '0;
      r_ys        <= '0;
      r_mirror    <= 1'b0;
      r_visible   <= 1'b0;
    end else begin
      r_vsyncPrev <= vsync_in;
      if (vsync_in && !r_vsyncPrev) begin
        r_xs      <= xpos;
        r_ys      <= ypos;
        r_mirror  <= mirror;
        r_visible <= visible;
      end
    end
  end

  // The box test uses 13-bit zero-extended values, so xs+64 cannot wrap.
  // A sprite near the right or bottom edge is clipped instead of
  // reappearing at the left or top. Inside the box the offset is below 64,
  // so the low six bits of the difference are the exact pixel offset.
  always_comb begin
    w_h13     = {2'b00, hcount_in};
    w_v13     = {2'b00, vcount_in};
    w_xs13    = {1'b0, r_xs};
    w_ys13    = {1'b0, r_ys};
    w_inBox   = (w_h13 >= w_xs13) && (w_h13 < w_xs13 + 13'(SPRITE_W)) &&
                (w_v13 >= w_ys13) && (w_v13 < w_ys13 + 13'(SPRITE_W));
    w_dx      = hcount_in[5:0] - r_xs[5:0];
    w_dy      = vcount_in[5:0] - r_ys[5:0];
    w_addrx   = r_mirror ? (6'd63 - w_dx) : w_dx;
    w_romAddr = w_inBox ? {w_dy, w_addrx} : 12'h000;
  end

  // Stage 1 issues the ROM address and delays the stream by one clock.
  // The visible flag travels with the pixel, so a shadow update in the
  // middle of the pipeline cannot affect a pixel that is already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Hcount  <= '0;
      r_s1Vcount  <= '0;
      r_s1Hsync   <= 1'b0;
      r_s1Vsync   <= 1'b0;
      r_s1Hblnk   <= 1'b0;
      r_s1Vblnk   <= 1'b0;
      r_s1Rgb     <= '0;
      r_s1InBox   <= 1'b0;
      r_s1Visible <= 1'b0;
      r_romAddr   <= '0;
    end else begin
      r_s1Hcount  <= hcount_in;
      r_s1Vcount  <= vcount_in;
      r_s1Hsync   <= hsync_in;
      r_s1Vsync   <= vsync_in;
      r_s1Hblnk   <= hblnk_in;
      r_s1Vblnk   <= vblnk_in;
      r_s1Rgb     <= rgb_in;
      r_s1InBox   <= w_inBox;
      r_s1Visible <= r_visible;
      r_romAddr   <= w_romAddr;
    end
  end

  // Stage 2 lines up with the ROM data. The ROM registers the address one
  // clock after it is issued, so its output is valid in the same cycle as
  // these registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2Hcount  <= '0;
      r_s2Vcount  <= '0;
      r_s2Hsync   <= 1'b0;
      r_s2Vsync   <= 1'b0;
      r_s2Hblnk   <= 1'b0;
      r_s2Vblnk   <= 1'b0;
      r_s2Rgb     <= '0;
      r_s2InBox   <= 1'b0;
      r_s2Visible <= 1'b0;
    end else begin
      r_s2Hcount  <= r_s1Hcount;
      r_s2Vcount  <= r_s1Vcount;
      r_s2Hsync   <= r_s1Hsync;
      r_s2Vsync   <= r_s1Vsync;
      r_s2Hblnk   <= r_s1Hblnk;
      r_s2Vblnk   <= r_s1Vblnk;
      r_s2Rgb     <= r_s1Rgb;
      r_s2InBox   <= r_s1InBox;
      r_s2Visible <= r_s1Visible;
    end
  end

  // Blanking forces black. Otherwise an opaque sprite pixel replaces the
  // background.
  always_comb begin
    rgb_out = r_s2Rgb;
    if (r_s2Hblnk || r_s2Vblnk) begin
      rgb_out = 12'h000;
    end else if (r_s2InBox && r_s2Visible && (rom_rgb != KEY_COLOR)) begin
      rgb_out = rom_rgb;
    end
  end

  assign rom_addr   = r_romAddr;
  assign hcount_out = r_s2Hcount;
  assign vcount_out = r_s2Vcount;
  assign hsync_out  = r_s2Hsync;
  assign vsync_out  = r_s2Vsync;
  assign hblnk_out  = r_s2Hblnk;
  assign vblnk_out  = r_s2Vblnk;

endmodule

// File: tb/tb_draw_player_ctl.sv
// Testbench for draw_player_ctl.
// A stimulus process drives one pixel per clock and pushes the expected
// responses into queues. Each response is tagged with the clock edge after
// which it must be visible. The expected values come from a frame-level
// model of the sprite rules. A separate monitor pops the queues and compares
// them with the DUT outputs on the falling edge.
module tb_draw_player_ctl;
  localparam logic [11:0] KEY = 12'h0F0;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos;
  logic        mirror, visible;
  logic [11:0] rom_addr, rom_rgb;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  always #5 clk = ~clk;

  draw_player_ctl #(.KEY_COLOR(KEY), .SPRITE_W(64)) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .mirror(mirror), .visible(visible),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // Sprite content. Every address whose low three bits equal 5 holds the
  // transparent colour.
  function automatic logic [11:0] romData(input logic [11:0] a);
    if (a[2:0] == 3'd5) return KEY;
    return (a * 12'd37) ^ 12'h9C3;
  endfunction

  // Synchronous ROM: the data is valid one clock after the address.
  always_ff @(posedge clk) rom_rgb <= romData(rom_addr);

  typedef struct {
    int          target;
    logic [10:0] hc, vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } outExp_t;

  typedef struct {
    int          target;
    logic [11:0] addr;
  } romExp_t;

  outExp_t outQ[$];
  romExp_t romQ[$];
  int edgeCount = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) edgeCount++;

  // Sprite controls as the model sees them at frame level.
  int mXs = 0, mYs = 0;
  bit mMirror = 0, mVisible = 0, mPrevVs = 0;

  // Values to drive on the next applyStimulus call.
  bit          dRst = 0;
  logic [10:0] dHc = 0, dVc = 0;
  bit          dHs = 0, dVs = 0, dHb = 0, dVb = 0;
  logic [11:0] dRgb = 0, dX = 0, dY = 0;
  bit          dMir = 0, dVis = 0;

  function automatic outExp_t zeroOut(input int t);
    outExp_t e;
    e.target = t; e.hc = 0; e.vc = 0; e.hs = 0; e.vs = 0;
    e.hb = 0; e.vb = 0; e.rgb = 0;
    return e;
  endfunction

  task automatic applyStimulus();
    outExp_t e;
    romExp_t r;
    int h, v, col, row;
    bit inBox;
    logic [11:0] addr, pix;
    @(posedge clk);
    #1;
    rst = dRst; hcount_in = dHc; vcount_in = dVc;
    hsync_in = dHs; vsync_in = dVs; hblnk_in = dHb; vblnk_in = dVb;
    rgb_in = dRgb; xpos = dX; ypos = dY; mirror = dMir; visible = dVis;
    if (dRst) begin
      // Reset clears everything at the next edge. The pixel that was
      // scheduled to appear after that edge is therefore lost.
      r.target = edgeCount + 1; r.addr = 12'h000;
      romQ.push_back(r);
      if (outQ.size() > 0 && outQ[outQ.size()-1].target == edgeCount + 1) begin
        void'(outQ.pop_back());
        outQ.push_back(zeroOut(edgeCount + 1));
      end
      outQ.push_back(zeroOut(edgeCount + 2));
      mXs = 0; mYs = 0; mMirror = 0; mVisible = 0; mPrevVs = 0;
    end else begin
      h = int'(dHc); v = int'(dVc);
      inBox = (h >= mXs) && (h < mXs + 64) && (v >= mYs) && (v < mYs + 64);
      col = mMirror ? 63 - (h - mXs) : (h - mXs);
      row = v - mYs;
      addr = inBox ? 12'(row * 64 + col) : 12'h000;
      pix = romData(addr);
      r.target = edgeCount + 1; r.addr = addr;
      romQ.push_back(r);
      e.target = edgeCount + 2; e.hc = dHc; e.vc = dVc; e.hs = dHs;
      e.vs = dVs; e.hb = dHb; e.vb = dVb;
      if (dHb || dVb) e.rgb = 12'h000;
      else if (inBox && mVisible && pix != KEY) e.rgb = pix;
      else e.rgb = dRgb;
      outQ.push_back(e);
      // This pixel used the old controls. A vsync rising edge makes the new
      // controls apply to the pixels that follow it.
      if (dVs && !mPrevVs) begin
        mXs = int'(dX); mYs = int'(dY); mMirror = dMir; mVisible = dVis;
      end
      mPrevVs = dVs;
    end
  endtask

  task automatic checkOutput(input string name, input logic [11:0] act,
                             input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at edge %0d: got %h expected %h", name,
               edgeCount, act, exp);
    end
  endtask

  // Monitor: compare every response that is due after the most recent edge.
  initial begin
    outExp_t e;
    romExp_t r;
    forever begin
      @(negedge clk);
      while (romQ.size() > 0 && romQ[0].target <= edgeCount) begin
        r = romQ.pop_front();
        if (r.target < edgeCount) checkOutput("rom_missed", 12'(r.target), 12'(edgeCount));
        else checkOutput("rom_addr", rom_addr, r.addr);
      end
      while (outQ.size() > 0 && outQ[0].target <= edgeCount) begin
        e = outQ.pop_front();
        if (e.target < edgeCount) checkOutput("out_missed", 12'(e.target), 12'(edgeCount));
        else begin
          checkOutput("hcount_out", {1'b0, hcount_out}, {1'b0, e.hc});
          checkOutput("vcount_out", {1'b0, vcount_out}, {1'b0, e.vc});
          checkOutput("hsync_out", {11'b0, hsync_out}, {11'b0, e.hs});
          checkOutput("vsync_out", {11'b0, vsync_out}, {11'b0, e.vs});
          checkOutput("hblnk_out", {11'b0, hblnk_out}, {11'b0, e.hb});
          checkOutput("vblnk_out", {11'b0, vblnk_out}, {11'b0, e.vb});
          checkOutput("rgb_out", rgb_out, e.rgb);
        end
      end
    end
  end

  task automatic pixel(input int h, input int v);
    dHc = 11'(h); dVc = 11'(v);
    applyStimulus();
  endtask

  task automatic vsyncEdge();
    dVs = 0; applyStimulus();
    dVs = 1; applyStimulus();
    dVs = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1; hcount_in = 0; vcount_in = 0; hsync_in = 0; vsync_in = 0;
    hblnk_in = 0; vblnk_in = 0; rgb_in = 0; xpos = 0; ypos = 0;
    mirror = 0; visible = 0;

    // Reset state. A pixel in the top-left box must not be drawn before the
    // first vsync edge, even when visible is driven high.
    dRst = 1; dRgb = 12'h123; dVis = 1;
    repeat (3) pixel(5, 5);
    dRst = 0;
    pixel(0, 0);
    pixel(10, 10);

    // Sprite at (100,200), facing right.
    dX = 100; dY = 200; dVis = 1; dMir = 0;
    vsyncEdge();
    pixel(100, 200);
    pixel(105, 200);
    pixel(163, 263);
    pixel(164, 200);
    pixel(99, 200);
    pixel(100, 264);
    dHb = 1; pixel(110, 210); dHb = 0;
    dVb = 1; pixel(110, 210); dVb = 0;

    // The same position, mirrored.
    dMir = 1;
    vsyncEdge();
    pixel(100, 203);
    pixel(140, 230);

    // A mid-frame move only takes effect after the next vsync edge.
    dX = 300;
    pixel(100, 210);
    pixel(300, 210);
    vsyncEdge();
    pixel(100, 210);
    pixel(300, 210);

    // Right-edge clipping, with no wrap to hcount 0..39.
    dX = 1000; dMir = 0;
    vsyncEdge();
    for (int h = 995; h < 1030; h++) pixel(h, 220);
    for (int h = 0; h < 42; h += 3) pixel(h, 220);

    // A reset pulse in the middle of a line hides the sprite until the next
    // vsync edge.
    dX = 100;
    vsyncEdge();
    pixel(110, 210);
    dHb = 1; pixel(111, 210); dHb = 0;
    dRst = 1; pixel(112, 210); dRst = 0;
    pixel(113, 210);
    dHb = 1; pixel(114, 210); dHb = 0;
    pixel(115, 210);
    vsyncEdge();
    pixel(116, 210);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      dRst = ($urandom_range(0, 299) == 0);
      dVs  = ($urandom_range(0, 39) == 0);
      dHs  = $urandom_range(0, 1);
      dHb  = ($urandom_range(0, 7) == 0);
      dVb  = ($urandom_range(0, 15) == 0);
      dRgb = 12'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        dX = 12'($urandom_range(0, 1100));
        dY = 12'($urandom_range(0, 800));
        dMir = $urandom_range(0, 1);
        dVis = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 9) < 7)
        pixel((int'(dX) + $urandom_range(0, 80) - 8) % 2048,
              (int'(dY) + $urandom_range(0, 80) - 8) % 2048);
      else
        pixel($urandom_range(0, 1343), $urandom_range(0, 805));
    end
    dRst = 0; dVs = 0;

    // Wait a bounded time for the queues to drain.
    for (int k = 0; k < 6 && (outQ.size() > 0 || romQ.size() > 0); k++)
      @(posedge clk);
    @(negedge clk);
    checkOutput("queue_drain", 12'(outQ.size() + romQ.size()), 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
